// File: rtl/lsu_rmw.sv
// Load/store unit with byte/halfword store via word read-modify-write.
// Latency: load 2, SW 2, SB/SH 3, rejected request 1 cycle from accept to resp_valid.
// Backpressure: req_ready only in IDLE; one request in flight, no queueing.
module lsu_rmw #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_load,
  input  logic                  req_store,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wd,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rd
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]            state;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [2:0]            f3_q;
  logic                  load_q;
  logic                  err_q;
  // Holds store data at accept; for SB/SH it is replaced by the merged word in RD.
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     rdata_q;

  logic                  req_err;
  logic [DATA_W-1:0]     lane;
  logic [DATA_W-1:0]     load_val;
  logic [DATA_W-1:0]     mask;
  logic [DATA_W-1:0]     rep;
  logic [DATA_W-1:0]     merged;

  // Classify the incoming request as illegal or misaligned.
  always_comb begin
    req_err = 1'b0;
    if (req_load == req_store) req_err = 1'b1;
    case (req_funct3)
      3'b011, 3'b110, 3'b111: req_err = 1'b1;
      3'b100, 3'b101:         if (req_store) req_err = 1'b1;
      default:                ;
    endcase
    if (req_funct3[1:0] == 2'b01 && req_addr[0]) req_err = 1'b1;
    if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00) req_err = 1'b1;
  end

  // Extract and extend the addressed lane of the memory word for loads.
  always_comb begin
    lane = mem_rd >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  load_val = {{(DATA_W-8){lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{(DATA_W-16){lane[15]}}, lane[15:0]};
      3'b100:  load_val = {{(DATA_W-8){1'b0}}, lane[7:0]};
      3'b101:  load_val = {{(DATA_W-16){1'b0}}, lane[15:0]};
      default: load_val = mem_rd;
    endcase
  end

  // Overlay the store byte/halfword onto the word read back from memory.
  always_comb begin
    if (f3_q[0]) begin
      mask = {{(DATA_W-16){1'b0}}, 16'hFFFF} << {addr_q[1:0], 3'b000};
      rep  = {2{wdata_q[15:0]}};
    end else begin
      mask = {{(DATA_W-8){1'b0}}, 8'hFF} << {addr_q[1:0], 3'b000};
      rep  = {4{wdata_q[7:0]}};
    end
    merged = (mem_rd & ~mask) | (rep & mask);
  end

  // Sequencer: accept in IDLE, then RD and/or WR, then a one-cycle RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      f3_q    <= 3'b000;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            f3_q    <= req_funct3;
            load_q  <= req_load;
            err_q   <= req_err;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            if (req_err)                   state <= ST_RESP;
            else if (req_load)             state <= ST_RD;
            else if (req_funct3 == 3'b010) state <= ST_WR;
            else                           state <= ST_RD;
          end
        end
        ST_RD: begin
          if (load_q) begin
            rdata_q <= load_val;
            state   <= ST_RESP;
          end else begin
            wdata_q <= merged;
            state   <= ST_WR;
          end
        end
        ST_WR:   state <= ST_RESP;
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign mem_read   = (state == ST_RD);
  assign mem_write  = (state == ST_WR);
  assign mem_addr   = {addr_q[DM_ADDRESS-1:2], 2'b00};
  assign mem_wd     = mem_write ? wdata_q : '0;
  assign mem_funct3 = 3'b010;

endmodule

// File: tb/tb_lsu_rmw.sv
// Bench for lsu_rmw: word-array memory, byte-level reference model, per-cycle checker.
// Directed request list with hand-computed expectations pinning the model.
// Requests wait on req_ready with bounded loops.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_load, req_store;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid, resp_err, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_wd, mem_rd;
  logic [8:0]  mem_addr;
  logic [2:0]  mem_funct3;

  always #5 clk = ~clk;

  lsu_rmw #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_store(req_store),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_funct3(mem_funct3), .mem_rd(mem_rd)
  );

  // Data memory seen by the DUT, and the model's own copy.
  logic [31:0] dmem    [0:127];
  logic [31:0] ref_mem [0:127];
  assign mem_rd = dmem[mem_addr[8:2]];
  always @(posedge clk) if (mem_write) dmem[mem_addr[8:2]] <= mem_wd;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: byte-array view of the addressed word.
  task automatic model_req(input bit ld, input bit st, input logic [8:0] a,
                           input logic [31:0] wd, input logic [2:0] f3,
                           output bit err, output logic [31:0] rd, output int lat,
                           output bit rds, output bit wrs, output logic [31:0] neww);
    int sz, off;
    logic [7:0] b [4];
    logic [31:0] w;
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(a) % 4;
    err = (ld == st) || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 ||
          (st && f3[2]) || (int'(a) % sz != 0);
    w = ref_mem[a[8:2]];
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    rd = 32'h0;
    neww = w;
    if (!err && ld) begin
      for (int i = 0; i < sz; i++) rd[8*i +: 8] = b[off+i];
      if (!f3[2] && sz < 4 && rd[8*sz-1])
        for (int i = sz; i < 4; i++) rd[8*i +: 8] = 8'hFF;
    end
    if (!err && st) begin
      for (int i = 0; i < sz; i++) b[off+i] = wd[8*i +: 8];
      for (int i = 0; i < 4; i++) neww[8*i +: 8] = b[i];
    end
    lat = err ? 1 : ld ? 2 : (sz == 4) ? 2 : 3;
    rds = !err && (ld || sz < 4);
    wrs = !err && st;
  endtask

  // Checker state for the one request in flight.
  bit          outstanding = 0;
  bit          e_err, e_rds, e_wrs;
  logic [31:0] e_rd, e_neww;
  logic [8:0]  e_addr;
  int          e_lat, acc_cyc, nrd, nwr;
  int          n_acc = 0, n_resp = 0, n_abort = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (outstanding) n_abort++;
      outstanding = 0;
    end else begin
      chk("strobe_excl", {31'b0, mem_read & mem_write}, 32'h0);
      chk("addr_align", {30'b0, mem_addr[1:0]}, 32'h0);
      if (!outstanding) begin
        chk("idle_ready", {31'b0, req_ready}, 32'h1);
        chk("idle_mem_read", {31'b0, mem_read}, 32'h0);
        chk("idle_mem_write", {31'b0, mem_write}, 32'h0);
        chk("idle_resp_valid", {31'b0, resp_valid}, 32'h0);
        if (req_valid && req_ready) begin
          model_req(req_load, req_store, req_addr, req_wdata, req_funct3,
                    e_err, e_rd, e_lat, e_rds, e_wrs, e_neww);
          e_addr = {req_addr[8:2], 2'b00};
          acc_cyc = cyc;
          nrd = 0;
          nwr = 0;
          outstanding = 1;
          n_acc++;
        end
      end else begin
        chk("busy_ready", {31'b0, req_ready}, 32'h0);
        if (mem_read) begin
          nrd++;
          chk("rd_addr", {23'b0, mem_addr}, {23'b0, e_addr});
        end
        if (mem_write) begin
          nwr++;
          chk("wr_addr", {23'b0, mem_addr}, {23'b0, e_addr});
          chk("wr_data", mem_wd, e_neww);
          chk("rd_before_wr", nrd, {31'b0, e_rds});
        end
        if (resp_valid) begin
          chk("resp_latency", cyc - acc_cyc, e_lat);
          chk("resp_err", {31'b0, resp_err}, {31'b0, e_err});
          chk("resp_rdata", resp_rdata, e_rd);
          chk("read_count", nrd, {31'b0, e_rds});
          chk("write_count", nwr, {31'b0, e_wrs});
          if (e_wrs) ref_mem[e_addr[8:2]] = e_neww;
          outstanding = 0;
          n_resp++;
        end
      end
    end
  end

  // Issue one request; pin the model against hand values when pin=1.
  task automatic do_req(input bit ld, input bit st, input logic [8:0] a,
                        input logic [31:0] wd, input logic [2:0] f3,
                        input bit pin, input bit lerr, input logic [31:0] lrd,
                        input bit keep);
    bit p_err, p_rds, p_wrs, got;
    logic [31:0] p_rd, p_nw;
    int p_lat;
    if (pin) begin
      model_req(ld, st, a, wd, f3, p_err, p_rd, p_lat, p_rds, p_wrs, p_nw);
      chk("pin_err", {31'b0, p_err}, {31'b0, lerr});
      chk("pin_rdata", p_rd, lrd);
    end
    req_load = ld; req_store = st; req_addr = a; req_wdata = wd; req_funct3 = f3;
    req_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req_ready) begin got = 1; break; end
    end
    if (!got) chk("accept_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    if (!keep) begin
      req_valid = 1'b0;
      got = 0;
      for (int i = 0; i < 30; i++) begin
        @(posedge clk);
        if (!outstanding) begin got = 1; break; end
      end
      if (!got) chk("resp_timeout", 32'h0, 32'h1);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) begin dmem[i] = 32'h0; ref_mem[i] = 32'h0; end
    dmem[16] = 32'h8899AABB; ref_mem[16] = 32'h8899AABB;
    dmem[4]  = 32'h11223344; ref_mem[4]  = 32'h11223344;
    reset = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_addr = '0; req_wdata = '0; req_funct3 = 3'b000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    chk("rst_mem_addr", {23'b0, mem_addr}, 32'h0);
    chk("mem_funct3", {29'b0, mem_funct3}, 32'h2);
    @(posedge clk); #1;

    //     ld    st    addr    wdata          f3   pin err rdata         keep
    do_req(1'b1, 1'b0, 9'h041, 32'h0,         3'd0, 1, 0, 32'hFFFFFFAA, 0);
    do_req(1'b1, 1'b0, 9'h042, 32'h0,         3'd5, 1, 0, 32'h00008899, 0);
    do_req(1'b1, 1'b0, 9'h043, 32'h0,         3'd1, 1, 1, 32'h00000000, 0);
    do_req(1'b0, 1'b1, 9'h042, 32'h123456CC,  3'd0, 1, 0, 32'h00000000, 0);
    chk("sb_merge_dmem", dmem[16], 32'h88CCAABB);
    chk("sb_merge_model", ref_mem[16], 32'h88CCAABB);
    do_req(1'b1, 1'b0, 9'h040, 32'h0,         3'd2, 1, 0, 32'h88CCAABB, 0);
    do_req(1'b0, 1'b1, 9'h1FC, 32'hDEADBEEF,  3'd2, 1, 0, 32'h00000000, 0);
    do_req(1'b1, 1'b0, 9'h1FC, 32'h0,         3'd2, 1, 0, 32'hDEADBEEF, 0);
    do_req(1'b1, 1'b1, 9'h040, 32'h0,         3'd2, 1, 1, 32'h00000000, 0);
    do_req(1'b1, 1'b0, 9'h043, 32'h0,         3'd4, 1, 0, 32'h00000088, 0);
    do_req(1'b1, 1'b0, 9'h040, 32'h0,         3'd1, 1, 0, 32'hFFFFAABB, 0);
    do_req(1'b1, 1'b0, 9'h040, 32'h0,         3'd0, 1, 0, 32'hFFFFFFBB, 0);
    do_req(1'b1, 1'b0, 9'h041, 32'h0,         3'd4, 1, 0, 32'h000000AA, 0);
    do_req(1'b0, 1'b1, 9'h042, 32'h00007E01,  3'd1, 1, 0, 32'h00000000, 0);
    do_req(1'b1, 1'b0, 9'h042, 32'h0,         3'd1, 1, 0, 32'h00007E01, 0);
    do_req(1'b1, 1'b0, 9'h043, 32'h0,         3'd0, 1, 0, 32'h0000007E, 0);
    // Illegal and misaligned forms.
    do_req(1'b0, 1'b1, 9'h040, 32'h1,         3'd4, 1, 1, 32'h00000000, 0);
    do_req(1'b1, 1'b0, 9'h040, 32'h0,         3'd3, 1, 1, 32'h00000000, 0);
    do_req(1'b0, 1'b1, 9'h042, 32'h1,         3'd2, 1, 1, 32'h00000000, 0);
    do_req(1'b1, 1'b0, 9'h041, 32'h0,         3'd2, 1, 1, 32'h00000000, 0);
    do_req(1'b1, 1'b0, 9'h040, 32'h0,         3'd6, 1, 1, 32'h00000000, 0);
    do_req(1'b0, 1'b0, 9'h040, 32'h0,         3'd2, 1, 1, 32'h00000000, 0);
    do_req(1'b1, 1'b0, 9'h041, 32'h0,         3'd5, 1, 1, 32'h00000000, 0);

    // SH aborted by reset while reading.
    req_load = 1'b0; req_store = 1'b1; req_addr = 9'h010;
    req_wdata = 32'h0000AAAA; req_funct3 = 3'd1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'b0, req_ready}, 32'h1);
    chk("abort_mem_write", {31'b0, mem_write}, 32'h0);
    chk("abort_mem_read", {31'b0, mem_read}, 32'h0);
    chk("abort_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("abort_mem_wd", mem_wd, 32'h0);
    chk("abort_mem_addr", {23'b0, mem_addr}, 32'h0);
    chk("abort_resp_rdata", resp_rdata, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_mem_kept", dmem[4], 32'h11223344);

    // Back-to-back with req_valid held high.
    do_req(1'b1, 1'b0, 9'h040, 32'h0,         3'd2, 0, 0, 32'h0, 1);
    do_req(1'b1, 1'b0, 9'h041, 32'h0,         3'd0, 0, 0, 32'h0, 1);
    do_req(1'b0, 1'b1, 9'h043, 32'h00000055,  3'd0, 0, 0, 32'h0, 1);
    do_req(1'b1, 1'b0, 9'h040, 32'h0,         3'd2, 0, 0, 32'h0, 1);
    do_req(1'b0, 1'b0, 9'h040, 32'h0,         3'd2, 0, 0, 32'h0, 0);
    chk("b2b_sb_dmem", dmem[16], 32'h5501AABB);

    repeat (3) @(posedge clk);
    chk("abort_count", n_abort, 32'd1);
    chk("resp_per_accept", n_resp, n_acc - n_abort);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
